axis_fifo_frame: RTL and testbench

- Single-clock, parametrised AXI4-Stream FIFO. Successor to the dual-clock stream FIFO, for blocks that share one clock domain.
- Adds real tstrb storage, selectable store-and-forward (frame) mode, oversize/overflow frame dropping, occupancy count and almost-full/almost-empty flags.
- Sits between DMA/stream sources and processing cores. In frame mode it guarantees that downstream never sees a partial packet.

---
 rtl/axis_fifo_frame.sv | 196 +++++++++++++++++++
 tb/tb_axis_fifo_frame.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_fifo_frame.sv
// Single-clock AXI4-Stream FIFO with per-beat tstrb storage and an optional
// store-and-forward (frame) mode that drops frames too large for the free space.
// The read side only ever sees committed entries, so in frame mode downstream
// never observes a partial packet. One registered output stage feeds m00.
module axis_fifo_frame #(
  parameter int unsigned C_AXIS_TDATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH          = 4,
  parameter bit          FRAME_FIFO          = 1'b1,
  parameter int unsigned ALMOST_FULL_THRESH  = 12,
  parameter int unsigned ALMOST_EMPTY_THRESH = 2
) (
  input  logic                            s00_axis_aclk,
  input  logic                            s00_axis_aresetn,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
  input  logic                            s00_axis_tvalid,
  output logic                            s00_axis_tready,
  input  logic                            s00_axis_tlast,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                            m00_axis_tvalid,
  input  logic                            m00_axis_tready,
  output logic                            m00_axis_tlast,
  output logic [ADDR_WIDTH:0]             fifo_count,
  output logic                            almost_full,
  output logic                            almost_empty,
  output logic                            overflow,
  output logic                            good_frame
);

  localparam int unsigned StrbWidth = C_AXIS_TDATA_WIDTH / 8;
  localparam int unsigned Depth     = 2 ** ADDR_WIDTH;
  localparam int unsigned PtrWidth  = ADDR_WIDTH + 1;
  localparam int unsigned MemWidth  = 1 + StrbWidth + C_AXIS_TDATA_WIDTH;

  localparam logic [PtrWidth-1:0] DepthPtr   = PtrWidth'(Depth);
  localparam logic [PtrWidth-1:0] PtrOne     = PtrWidth'(1);
  localparam logic [PtrWidth-1:0] AfThresh   = PtrWidth'(ALMOST_FULL_THRESH);
  localparam logic [PtrWidth-1:0] AeThresh   = PtrWidth'(ALMOST_EMPTY_THRESH);

  // Storage: each entry is {tlast, tstrb, tdata}; contents are never reset.
  logic [MemWidth-1:0] mem_q [Depth];
  logic                mem_we;
  logic [MemWidth-1:0] mem_wdata;
  logic [MemWidth-1:0] mem_rdata;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0] wr_ptr_commit_q, wr_ptr_commit_d;
  logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic                drop_q, drop_d;
  logic                overflow_q, overflow_d;
  logic                good_frame_q, good_frame_d;
  logic                in_ready_q;

  // Output register stage.
  logic                          out_valid_q, out_valid_d;
  logic [C_AXIS_TDATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [StrbWidth-1:0]          out_strb_q, out_strb_d;
  logic                          out_last_q, out_last_d;

  logic                          rd_last;
  logic [StrbWidth-1:0]          rd_strb;
  logic [C_AXIS_TDATA_WIDTH-1:0] rd_data;

  logic full;
  logic empty;
  logic wr_fire;
  logic rd_load;

  assign full    = (wr_ptr_q - rd_ptr_q) == DepthPtr;
  assign empty   = (wr_ptr_commit_q == rd_ptr_q);
  assign wr_fire = s00_axis_tvalid & s00_axis_tready;
  assign rd_load = (~out_valid_q | m00_axis_tready) & ~empty;

  assign mem_wdata = {s00_axis_tlast, s00_axis_tstrb, s00_axis_tdata};
  assign mem_rdata = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
  assign {rd_last, rd_strb, rd_data} = mem_rdata;

  // Input ready: frame mode never stalls the source; a beat that finds the
  // memory full aborts the frame instead. Held low until the first clock after reset.
  always_comb begin
    s00_axis_tready = 1'b0;
    if (FRAME_FIFO) begin
      s00_axis_tready = in_ready_q;
    end else begin
      s00_axis_tready = in_ready_q & ~full;
    end
  end

  // Write-side next state: pointer advance, commit, frame drop and status pulses.
  always_comb begin
    wr_ptr_d        = wr_ptr_q;
    wr_ptr_commit_d = wr_ptr_commit_q;
    drop_d          = drop_q;
    overflow_d      = 1'b0;
    good_frame_d    = 1'b0;
    mem_we          = 1'b0;
    if (wr_fire) begin
      if (!FRAME_FIFO) begin
        mem_we          = 1'b1;
        wr_ptr_d        = wr_ptr_q + PtrOne;
        wr_ptr_commit_d = wr_ptr_q + PtrOne;
        good_frame_d    = s00_axis_tlast;
      end else if (drop_q) begin
        // Swallow the rest of an aborted frame; its tlast ends the drop.
        if (s00_axis_tlast) begin
          drop_d     = 1'b0;
          overflow_d = 1'b1;
        end
      end else if (full) begin
        // Frame does not fit: throw away its partial beats and this one.
        wr_ptr_d = wr_ptr_commit_q;
        if (s00_axis_tlast) begin
          overflow_d = 1'b1;
        end else begin
          drop_d = 1'b1;
        end
      end else begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PtrOne;
        if (s00_axis_tlast) begin
          wr_ptr_commit_d = wr_ptr_q + PtrOne;
          good_frame_d    = 1'b1;
        end
      end
    end
  end

  // Read-side next state: refill the output register whenever it is free or draining.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_strb_d  = out_strb_q;
    out_last_d  = out_last_q;
    if (rd_load) begin
      rd_ptr_d    = rd_ptr_q + PtrOne;
      out_valid_d = 1'b1;
      out_data_d  = rd_data;
      out_strb_d  = rd_strb;
      out_last_d  = rd_last;
    end else if (m00_axis_tready) begin
      out_valid_d = 1'b0;
    end
  end

  // Memory write port (no reset on the array).
  always_ff @(posedge s00_axis_aclk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= mem_wdata;
    end
  end

  // Pointer, flag and output-stage registers.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      wr_ptr_q        <= '0;
      wr_ptr_commit_q <= '0;
      rd_ptr_q        <= '0;
      drop_q          <= 1'b0;
      overflow_q      <= 1'b0;
      good_frame_q    <= 1'b0;
      in_ready_q      <= 1'b0;
      out_valid_q     <= 1'b0;
      out_data_q      <= '0;
      out_strb_q      <= '0;
      out_last_q      <= 1'b0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      wr_ptr_commit_q <= wr_ptr_commit_d;
      rd_ptr_q        <= rd_ptr_d;
      drop_q          <= drop_d;
      overflow_q      <= overflow_d;
      good_frame_q    <= good_frame_d;
      in_ready_q      <= 1'b1;
      out_valid_q     <= out_valid_d;
      out_data_q      <= out_data_d;
      out_strb_q      <= out_strb_d;
      out_last_q      <= out_last_d;
    end
  end

  assign m00_axis_tvalid = out_valid_q;
  assign m00_axis_tdata  = out_data_q;
  assign m00_axis_tstrb  = out_strb_q;
  assign m00_axis_tlast  = out_last_q;

  // Occupancy counts committed entries still in memory, not the output register.
  assign fifo_count   = wr_ptr_commit_q - rd_ptr_q;
  assign almost_full  = (fifo_count >= AfThresh);
  assign almost_empty = (fifo_count <= AeThresh);
  assign overflow     = overflow_q;
  assign good_frame   = good_frame_q;

endmodule

// File: tb/tb_axis_fifo_frame.sv
// Bench for axis_fifo_frame: one plain (cut-through) and one frame-mode instance
// share clock and reset. Expected beats are queued when driven, popped on output.
module tb_axis_fifo_frame;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int AW = 4;

  typedef logic [DW+SW:0] beat_t;  // {tlast, tstrb, tdata}

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] p_s_tdata, p_m_tdata, f_s_tdata, f_m_tdata;
  logic [SW-1:0] p_s_tstrb, p_m_tstrb, f_s_tstrb, f_m_tstrb;
  logic p_s_tvalid, p_s_tready, p_s_tlast, p_m_tvalid, p_m_tready, p_m_tlast;
  logic f_s_tvalid, f_s_tready, f_s_tlast, f_m_tvalid, f_m_tready, f_m_tlast;
  logic [AW:0] p_count, f_count;
  logic p_af, p_ae, p_ov, p_gf, f_af, f_ae, f_ov, f_gf;

  beat_t sb_p[$];
  beat_t sb_f[$];
  int n_cmp = 0;
  int n_err = 0;
  int p_gf_n = 0;
  int f_gf_n = 0;
  int f_ov_n = 0;

  axis_fifo_frame #(
    .C_AXIS_TDATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_FIFO(1'b0),
    .ALMOST_FULL_THRESH(12), .ALMOST_EMPTY_THRESH(2)
  ) u_plain (
    .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
    .s00_axis_tdata(p_s_tdata), .s00_axis_tstrb(p_s_tstrb), .s00_axis_tvalid(p_s_tvalid),
    .s00_axis_tready(p_s_tready), .s00_axis_tlast(p_s_tlast),
    .m00_axis_tdata(p_m_tdata), .m00_axis_tstrb(p_m_tstrb), .m00_axis_tvalid(p_m_tvalid),
    .m00_axis_tready(p_m_tready), .m00_axis_tlast(p_m_tlast),
    .fifo_count(p_count), .almost_full(p_af), .almost_empty(p_ae),
    .overflow(p_ov), .good_frame(p_gf)
  );

  axis_fifo_frame #(
    .C_AXIS_TDATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_FIFO(1'b1),
    .ALMOST_FULL_THRESH(12), .ALMOST_EMPTY_THRESH(2)
  ) u_frame (
    .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
    .s00_axis_tdata(f_s_tdata), .s00_axis_tstrb(f_s_tstrb), .s00_axis_tvalid(f_s_tvalid),
    .s00_axis_tready(f_s_tready), .s00_axis_tlast(f_s_tlast),
    .m00_axis_tdata(f_m_tdata), .m00_axis_tstrb(f_m_tstrb), .m00_axis_tvalid(f_m_tvalid),
    .m00_axis_tready(f_m_tready), .m00_axis_tlast(f_m_tlast),
    .fifo_count(f_count), .almost_full(f_af), .almost_empty(f_ae),
    .overflow(f_ov), .good_frame(f_gf)
  );

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (p_gf === 1'b1) p_gf_n++;
    if (f_gf === 1'b1) f_gf_n++;
    if (f_ov === 1'b1) f_ov_n++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one beat into the plain instance; returns at posedge+1 after the transfer.
  task automatic send_p(input beat_t b);
    int wait_n = 0;
    {p_s_tlast, p_s_tstrb, p_s_tdata} = b;
    p_s_tvalid = 1'b1;
    @(negedge clk);
    while (p_s_tready !== 1'b1 && wait_n < 200) begin @(negedge clk); wait_n++; end
    n_cmp++;
    if (p_s_tready !== 1'b1) begin
      n_err++; $display("FAIL send_p accept: tready %b want 1", p_s_tready);
    end
    @(posedge clk); #1;
    p_s_tvalid = 1'b0;
  endtask

  task automatic send_f(input beat_t b);
    int wait_n = 0;
    {f_s_tlast, f_s_tstrb, f_s_tdata} = b;
    f_s_tvalid = 1'b1;
    @(negedge clk);
    while (f_s_tready !== 1'b1 && wait_n < 200) begin @(negedge clk); wait_n++; end
    n_cmp++;
    if (f_s_tready !== 1'b1) begin
      n_err++; $display("FAIL send_f accept: tready %b want 1", f_s_tready);
    end
    @(posedge clk); #1;
    f_s_tvalid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (f_s_tready !== 1'b0) begin n_err++; $display("FAIL rst f_tready: got %b want 0", f_s_tready); end
    n_cmp++; if (p_s_tready !== 1'b0) begin n_err++; $display("FAIL rst p_tready: got %b want 0", p_s_tready); end
    n_cmp++; if (f_m_tvalid !== 1'b0) begin n_err++; $display("FAIL rst f_tvalid: got %b want 0", f_m_tvalid); end
    n_cmp++; if (p_m_tvalid !== 1'b0) begin n_err++; $display("FAIL rst p_tvalid: got %b want 0", p_m_tvalid); end
    n_cmp++; if (f_count !== 5'd0) begin n_err++; $display("FAIL rst count: got %0d want 0", f_count); end
    n_cmp++; if (f_ae !== 1'b1) begin n_err++; $display("FAIL rst almost_empty: got %b want 1", f_ae); end
    n_cmp++; if (f_af !== 1'b0) begin n_err++; $display("FAIL rst almost_full: got %b want 0", f_af); end
    n_cmp++; if (f_ov !== 1'b0 || p_ov !== 1'b0) begin n_err++; $display("FAIL rst overflow: got %b/%b want 0", f_ov, p_ov); end
    n_cmp++; if (f_gf !== 1'b0) begin n_err++; $display("FAIL rst good_frame: got %b want 0", f_gf); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (f_s_tready !== 1'b1) begin n_err++; $display("FAIL rel f_tready: got %b want 1", f_s_tready); end
    n_cmp++; if (p_s_tready !== 1'b1) begin n_err++; $display("FAIL rel p_tready: got %b want 1", p_s_tready); end
  endtask

  // Plain mode fill with the sink stalled. The first beat moves into the output
  // register, so 17 beats are taken before memory reports 16 and tready drops.
  task automatic test_plain_fill;
    int got = 0;
    int budget = 0;
    int gf_base = p_gf_n;
    beat_t e;
    p_m_tready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      beat_t b;
      b = {(i == 7 || i == 16) ? 1'b1 : 1'b0, 4'(i * 3 + 1), 32'(i)};
      sb_p.push_back(b);
      send_p(b);
      if (i == 2) begin
        n_cmp++; if (p_ae !== 1'b1) begin n_err++; $display("FAIL ae_at_2: got %b want 1", p_ae); end
      end
      if (i == 3) begin
        n_cmp++; if (p_ae !== 1'b0) begin n_err++; $display("FAIL ae_at_3: got %b want 0", p_ae); end
      end
      if (i == 11) begin
        n_cmp++; if (p_af !== 1'b0) begin n_err++; $display("FAIL af_at_11: got %b want 0", p_af); end
      end
      if (i == 12) begin
        n_cmp++; if (p_af !== 1'b1) begin n_err++; $display("FAIL af_at_12: got %b want 1", p_af); end
      end
      if (i == 15) begin
        n_cmp++; if (p_s_tready !== 1'b1) begin n_err++; $display("FAIL ready_at_15: got %b want 1", p_s_tready); end
      end
    end
    n_cmp++; if (p_s_tready !== 1'b0) begin n_err++; $display("FAIL full tready: got %b want 0", p_s_tready); end
    n_cmp++; if (p_count !== 5'd16) begin n_err++; $display("FAIL full count: got %0d want 16", p_count); end
    n_cmp++; if (p_af !== 1'b1) begin n_err++; $display("FAIL full almost_full: got %b want 1", p_af); end
    // An extra beat must be refused while full.
    p_s_tdata = 32'h55; p_s_tstrb = 4'h1; p_s_tlast = 1'b0; p_s_tvalid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_cmp++; if (p_s_tready !== 1'b0) begin n_err++; $display("FAIL refuse: tready %b want 0", p_s_tready); end
    end
    @(posedge clk); #1;
    p_s_tvalid = 1'b0;
    p_m_tready = 1'b1;
    while (got < 17 && budget < 100) begin
      @(negedge clk);
      budget++;
      if (p_m_tvalid === 1'b1) begin
        got++;
        n_cmp++;
        if (sb_p.size() == 0) begin
          n_err++; $display("FAIL plain extra beat: got %h want none", p_m_tdata);
        end else begin
          e = sb_p.pop_front();
          if ({p_m_tlast, p_m_tstrb, p_m_tdata} !== e) begin
            n_err++; $display("FAIL plain beat: got %h want %h", {p_m_tlast, p_m_tstrb, p_m_tdata}, e);
          end
        end
      end
    end
    n_cmp++; if (got != 17) begin n_err++; $display("FAIL plain drain: got %0d beats want 17", got); end
    @(negedge clk);
    n_cmp++; if (p_m_tvalid !== 1'b0) begin n_err++; $display("FAIL plain empty tvalid: got %b want 0", p_m_tvalid); end
    n_cmp++; if (p_count !== 5'd0) begin n_err++; $display("FAIL plain empty count: got %0d want 0", p_count); end
    n_cmp++; if (p_gf_n - gf_base != 2) begin n_err++; $display("FAIL plain good_frame: got %0d want 2", p_gf_n - gf_base); end
    @(posedge clk); #1;
  endtask

  task automatic test_frame_latency;
    int gf_base = f_gf_n;
    beat_t e;
    f_m_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      beat_t b;
      b = {(i == 3) ? 1'b1 : 1'b0, 4'hF, 32'hA0 + 32'(i)};
      sb_f.push_back(b);
      send_f(b);
      n_cmp++; if (f_m_tvalid !== 1'b0) begin n_err++; $display("FAIL latency early tvalid: beat %0d got %b want 0", i, f_m_tvalid); end
      if (i < 3) begin
        n_cmp++; if (f_count !== 5'd0) begin n_err++; $display("FAIL uncommitted count: got %0d want 0", f_count); end
      end
    end
    n_cmp++; if (f_gf !== 1'b1) begin n_err++; $display("FAIL good_frame pulse: got %b want 1", f_gf); end
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (f_m_tvalid !== 1'b1) begin
        n_err++; $display("FAIL latency b2b tvalid: beat %0d got %b want 1", k, f_m_tvalid);
      end else if (sb_f.size() != 0) begin
        e = sb_f.pop_front();
        if ({f_m_tlast, f_m_tstrb, f_m_tdata} !== e) begin
          n_err++; $display("FAIL latency beat: got %h want %h", {f_m_tlast, f_m_tstrb, f_m_tdata}, e);
        end
      end
    end
    @(negedge clk);
    n_cmp++; if (f_m_tvalid !== 1'b0) begin n_err++; $display("FAIL latency tail tvalid: got %b want 0", f_m_tvalid); end
    n_cmp++; if (f_gf_n - gf_base != 1) begin n_err++; $display("FAIL latency gf count: got %0d want 1", f_gf_n - gf_base); end
    sb_f.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_overflow;
    int ov_base = f_ov_n;
    int gf_base = f_gf_n;
    int got = 0;
    int budget = 0;
    beat_t e;
    f_m_tready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      send_f({(i == 19) ? 1'b1 : 1'b0, 4'hF, 32'h100 + 32'(i)});
    end
    n_cmp++; if (f_ov !== 1'b1) begin n_err++; $display("FAIL overflow pulse: got %b want 1", f_ov); end
    n_cmp++; if (f_count !== 5'd0) begin n_err++; $display("FAIL overflow count: got %0d want 0", f_count); end
    n_cmp++; if (f_m_tvalid !== 1'b0) begin n_err++; $display("FAIL overflow tvalid: got %b want 0", f_m_tvalid); end
    @(posedge clk); #1;
    n_cmp++; if (f_ov !== 1'b0) begin n_err++; $display("FAIL overflow width: got %b want 0", f_ov); end
    for (int i = 0; i < 2; i++) begin
      beat_t b;
      b = {(i == 1) ? 1'b1 : 1'b0, 4'(i + 3), 32'hB0 + 32'(i)};
      sb_f.push_back(b);
      send_f(b);
    end
    f_m_tready = 1'b1;
    while (got < 2 && budget < 50) begin
      @(negedge clk);
      budget++;
      if (f_m_tvalid === 1'b1) begin
        got++;
        n_cmp++;
        if (sb_f.size() == 0) begin
          n_err++; $display("FAIL after-drop extra beat: got %h want none", f_m_tdata);
        end else begin
          e = sb_f.pop_front();
          if ({f_m_tlast, f_m_tstrb, f_m_tdata} !== e) begin
            n_err++; $display("FAIL after-drop beat: got %h want %h", {f_m_tlast, f_m_tstrb, f_m_tdata}, e);
          end
        end
      end
    end
    n_cmp++; if (got != 2) begin n_err++; $display("FAIL after-drop count: got %0d want 2", got); end
    @(negedge clk);
    n_cmp++; if (f_m_tvalid !== 1'b0) begin n_err++; $display("FAIL after-drop tvalid: got %b want 0", f_m_tvalid); end
    n_cmp++; if (f_ov_n - ov_base != 1) begin n_err++; $display("FAIL overflow total: got %0d want 1", f_ov_n - ov_base); end
    n_cmp++; if (f_gf_n - gf_base != 1) begin n_err++; $display("FAIL drop gf total: got %0d want 1", f_gf_n - gf_base); end
    @(posedge clk); #1;
  endtask

  task automatic test_streaming;
    f_m_tready = 1'b1;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          beat_t b;
          b = {1'b1, 4'($urandom), 32'($urandom)};
          sb_f.push_back(b);
          send_f(b);
        end
      end
      begin
        int got = 0;
        int cyc = 0;
        bit started = 1'b0;
        beat_t e;
        while (got < 100 && cyc < 400) begin
          @(negedge clk);
          cyc++;
          n_cmp++; if (f_count > 5'd2) begin n_err++; $display("FAIL stream count: got %0d want <=2", f_count); end
          n_cmp++; if (f_ov !== 1'b0) begin n_err++; $display("FAIL stream overflow: got %b want 0", f_ov); end
          if (started) begin
            n_cmp++; if (f_m_tvalid !== 1'b1) begin n_err++; $display("FAIL stream bubble: tvalid %b want 1", f_m_tvalid); end
          end
          if (f_m_tvalid === 1'b1) begin
            started = 1'b1;
            got++;
            n_cmp++;
            if (sb_f.size() == 0) begin
              n_err++; $display("FAIL stream extra beat: got %h want none", f_m_tdata);
            end else begin
              e = sb_f.pop_front();
              if ({f_m_tlast, f_m_tstrb, f_m_tdata} !== e) begin
                n_err++; $display("FAIL stream beat: got %h want %h", {f_m_tlast, f_m_tstrb, f_m_tdata}, e);
              end
            end
          end
        end
        n_cmp++; if (got != 100) begin n_err++; $display("FAIL stream total: got %0d want 100", got); end
      end
    join
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    fork
      begin
        for (int fr = 0; fr < 3; fr++) begin
          for (int j = 0; j < 5; j++) begin
            beat_t b;
            b = {(j == 4) ? 1'b1 : 1'b0, 4'($urandom), 32'hF000 + 32'(fr * 16 + j)};
            sb_f.push_back(b);
            send_f(b);
          end
        end
      end
      begin
        int got = 0;
        int cyc = 0;
        beat_t e;
        while (got < 15 && cyc < 1000) begin
          @(posedge clk); #1;
          f_m_tready = 1'($urandom_range(0, 1));
          @(negedge clk);
          cyc++;
          if (f_m_tvalid === 1'b1 && f_m_tready === 1'b1) begin
            got++;
            n_cmp++;
            if (sb_f.size() == 0) begin
              n_err++; $display("FAIL bp extra beat: got %h want none", f_m_tdata);
            end else begin
              e = sb_f.pop_front();
              if ({f_m_tlast, f_m_tstrb, f_m_tdata} !== e) begin
                n_err++; $display("FAIL bp beat: got %h want %h", {f_m_tlast, f_m_tstrb, f_m_tdata}, e);
              end
            end
          end
        end
        n_cmp++; if (got != 15) begin n_err++; $display("FAIL bp total: got %0d want 15", got); end
      end
    join
    @(negedge clk);
    n_cmp++; if (f_count !== 5'd0) begin n_err++; $display("FAIL bp final count: got %0d want 0", f_count); end
    n_cmp++; if (f_m_tvalid !== 1'b0) begin n_err++; $display("FAIL bp final tvalid: got %b want 0", f_m_tvalid); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int ov_base = f_ov_n;
    int got = 0;
    int budget = 0;
    beat_t e;
    f_m_tready = 1'b0;
    send_f({1'b0, 4'hF, 32'hD0});
    send_f({1'b1, 4'hF, 32'hD1});
    @(posedge clk); #1;
    n_cmp++; if (f_count !== 5'd1) begin n_err++; $display("FAIL pre-reset count: got %0d want 1", f_count); end
    n_cmp++; if (f_m_tvalid !== 1'b1) begin n_err++; $display("FAIL pre-reset tvalid: got %b want 1", f_m_tvalid); end
    send_f({1'b0, 4'hF, 32'hE0});
    send_f({1'b0, 4'hF, 32'hE1});
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (f_m_tvalid !== 1'b0) begin n_err++; $display("FAIL mid-reset tvalid: got %b want 0", f_m_tvalid); end
    n_cmp++; if (f_count !== 5'd0) begin n_err++; $display("FAIL mid-reset count: got %0d want 0", f_count); end
    n_cmp++; if (f_ov !== 1'b0) begin n_err++; $display("FAIL mid-reset overflow: got %b want 0", f_ov); end
    n_cmp++; if (f_s_tready !== 1'b0) begin n_err++; $display("FAIL mid-reset tready: got %b want 0", f_s_tready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    f_m_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      beat_t b;
      b = {(i == 2) ? 1'b1 : 1'b0, 4'(1 << i), 32'hC0 + 32'(i)};
      sb_f.push_back(b);
      send_f(b);
    end
    while (got < 3 && budget < 50) begin
      @(negedge clk);
      budget++;
      if (f_m_tvalid === 1'b1) begin
        got++;
        n_cmp++;
        if (sb_f.size() == 0) begin
          n_err++; $display("FAIL post-reset extra beat: got %h want none", f_m_tdata);
        end else begin
          e = sb_f.pop_front();
          if ({f_m_tlast, f_m_tstrb, f_m_tdata} !== e) begin
            n_err++; $display("FAIL post-reset beat: got %h want %h", {f_m_tlast, f_m_tstrb, f_m_tdata}, e);
          end
        end
      end
    end
    n_cmp++; if (got != 3) begin n_err++; $display("FAIL post-reset total: got %0d want 3", got); end
    @(negedge clk);
    n_cmp++; if (f_m_tvalid !== 1'b0) begin n_err++; $display("FAIL post-reset stale tvalid: got %b want 0", f_m_tvalid); end
    n_cmp++; if (f_ov_n != ov_base) begin n_err++; $display("FAIL reset overflow pulses: got %0d want 0", f_ov_n - ov_base); end
    @(posedge clk); #1;
  endtask

  initial begin
    p_s_tdata = '0; p_s_tstrb = '0; p_s_tvalid = 1'b0; p_s_tlast = 1'b0; p_m_tready = 1'b0;
    f_s_tdata = '0; f_s_tstrb = '0; f_s_tvalid = 1'b0; f_s_tlast = 1'b0; f_m_tready = 1'b0;
    test_reset;
    test_plain_fill;
    test_frame_latency;
    test_overflow;
    test_streaming;
    test_backpressure;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
